// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
// Holds the controller state encoding and the default operand width.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter must be able to hold WIDTH-1 for any legal WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full-adder cell used as the shared slice of the serial adder.
module fulladder (
  output logic sum,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice walks the operands
// LSB-first over WIDTH cycles, with the running carry held in a flop.
//
// state  | meaning
// IDLE   | waiting for start, no result yet
// RUN    | one operand bit pair consumed per cycle
// DONE   | result/carry_out/overflow valid, waiting for next start
module serial_adder_ctrl
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
    $error("serial_adder_ctrl: WIDTH must be in 1..32");
  end

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] a_sh_q,      a_sh_d;
  logic [WIDTH-1:0] b_sh_q,      b_sh_d;
  logic [WIDTH-1:0] res_q,       res_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             carry_q,     carry_d;
  logic             msb_cin_q,   msb_cin_d;
  logic             carry_out_q, carry_out_d;

  logic fa_sum;
  logic fa_co;

  fulladder u_slice (
    .sum (fa_sum),
    .co  (fa_co),
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .ci  (carry_q)
  );

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    msb_cin_d   = msb_cin_q;
    carry_out_d = carry_out_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B and seed the carry with sub.
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        res_d   = (res_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == LAST_BIT) begin
          // The carry entering the sign bit is needed for signed overflow.
          msb_cin_d   = carry_q;
          carry_out_d = fa_co;
          state_d     = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      msb_cin_q   <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      msb_cin_q   <= msb_cin_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = res_q;
  assign carry_out = carry_out_q;
  assign overflow  = msb_cin_q ^ carry_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8, 1 and 3, using a
// vector table, hand-written corner sequences and an arithmetic reference model.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // WIDTH=8 instance
  logic       rst_n8, start8, sub8;
  logic [7:0] a8, b8;
  logic       busy8, done8, co8, ov8;
  logic [7:0] res8;

  // WIDTH=1 instance
  logic       rst_n1, start1, sub1;
  logic [0:0] a1, b1;
  logic       busy1, done1, co1, ov1;
  logic [0:0] res1;

  // WIDTH=3 instance
  logic       rst_n3, start3, sub3;
  logic [2:0] a3, b3;
  logic       busy3, done3, co3, ov3;
  logic [2:0] res3;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .carry_out(co8), .overflow(ov8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(res1), .carry_out(co1), .overflow(ov1)
  );

  serial_adder_ctrl #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n3), .start(start3), .sub(sub3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .result(res3), .carry_out(co3), .overflow(ov3)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] res;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int w, input int unsigned ia, input int unsigned ib,
                                input bit is, output int unsigned er,
                                output bit eco, output bit eov);
    longint m, sa, sb, ur, sr;
    m  = longint'(1) << w;
    sa = (longint'(ia) >= m / 2) ? longint'(ia) - m : longint'(ia);
    sb = (longint'(ib) >= m / 2) ? longint'(ib) - m : longint'(ib);
    ur = is ? longint'(ia) - longint'(ib) : longint'(ia) + longint'(ib);
    sr = is ? sa - sb : sa + sb;
    er  = 32'(((ur % m) + m) % m);
    eco = is ? (ia >= ib) : (ur >= m);
    eov = (sr < -(m / 2)) || (sr > (m / 2) - 1);
  endfunction

  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                      input logic [7:0] er, input logic eco, input logic eov,
                      input string nm);
    @(negedge clk);
    a8 = ia; b8 = ib; sub8 = is; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    // Operands need not be held after the sampling edge.
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      check({nm, ".busy"}, 32'(busy8), 32'd1);
      check({nm, ".done_low"}, 32'(done8), 32'd0);
      if (i < 7) @(negedge clk);
    end
    @(negedge clk);
    check({nm, ".busy_end"}, 32'(busy8), 32'd0);
    check({nm, ".done"}, 32'(done8), 32'd1);
    check({nm, ".result"}, 32'(res8), 32'(er));
    check({nm, ".carry_out"}, 32'(co8), 32'(eco));
    check({nm, ".overflow"}, 32'(ov8), 32'(eov));
  endtask

  task automatic run_small(input int w, input int unsigned ia, input int unsigned ib,
                           input bit is);
    int unsigned er;
    bit eco, eov;
    model(w, ia, ib, is, er, eco, eov);
    @(negedge clk);
    if (w == 1) begin
      a1 = 1'(ia); b1 = 1'(ib); sub1 = is; start1 = 1'b1;
    end else begin
      a3 = 3'(ia); b3 = 3'(ib); sub3 = is; start3 = 1'b1;
    end
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    for (int i = 0; i < w; i++) begin
      check($sformatf("w%0d.busy", w), 32'((w == 1) ? busy1 : busy3), 32'd1);
      if (i < w - 1) @(negedge clk);
    end
    @(negedge clk);
    if (w == 1) begin
      check("w1.done", 32'(done1), 32'd1);
      check($sformatf("w1.result a=%0d b=%0d sub=%0d", ia, ib, is), 32'(res1), er);
      check($sformatf("w1.carry a=%0d b=%0d sub=%0d", ia, ib, is), 32'(co1), 32'(eco));
      check($sformatf("w1.ovf a=%0d b=%0d sub=%0d", ia, ib, is), 32'(ov1), 32'(eov));
    end else begin
      check("w3.done", 32'(done3), 32'd1);
      check($sformatf("w3.result a=%0d b=%0d sub=%0d", ia, ib, is), 32'(res3), er);
      check($sformatf("w3.carry a=%0d b=%0d sub=%0d", ia, ib, is), 32'(co3), 32'(eco));
      check($sformatf("w3.ovf a=%0d b=%0d sub=%0d", ia, ib, is), 32'(ov3), 32'(eov));
    end
  endtask

  initial begin
    int unsigned er;
    bit eco, eov;
    logic [7:0] ra, rb;
    logic rs;

    vecs[0] = '{a: 8'h35, b: 8'h4A, sub: 1'b0, res: 8'h7F, co: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, res: 8'h00, co: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, res: 8'h80, co: 1'b0, ov: 1'b1};
    vecs[3] = '{a: 8'h10, b: 8'h20, sub: 1'b1, res: 8'hF0, co: 1'b0, ov: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, sub: 1'b1, res: 8'h7F, co: 1'b1, ov: 1'b1};
    vecs[5] = '{a: 8'h00, b: 8'h00, sub: 1'b1, res: 8'h00, co: 1'b1, ov: 1'b0};
    vecs[6] = '{a: 8'h80, b: 8'h80, sub: 1'b0, res: 8'h00, co: 1'b1, ov: 1'b1};

    rst_n8 = 1'b0; start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    rst_n1 = 1'b0; start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    rst_n3 = 1'b0; start3 = 1'b0; sub3 = 1'b0; a3 = '0; b3 = '0;

    repeat (3) @(negedge clk);
    check("rst.busy8", 32'(busy8), 32'd0);
    check("rst.done8", 32'(done8), 32'd0);
    check("rst.result8", 32'(res8), 32'd0);
    check("rst.carry8", 32'(co8), 32'd0);
    check("rst.ovf8", 32'(ov8), 32'd0);
    check("rst.busy1", 32'(busy1), 32'd0);
    check("rst.done3", 32'(done3), 32'd0);
    rst_n8 = 1'b1; rst_n1 = 1'b1; rst_n3 = 1'b1;

    // Start held low: IDLE persists.
    repeat (2) @(negedge clk);
    check("idle.busy8", 32'(busy8), 32'd0);
    check("idle.done8", 32'(done8), 32'd0);

    for (int i = 0; i < 7; i++)
      run8(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].res, vecs[i].co, vecs[i].ov,
           $sformatf("vec%0d", i));

    // Start pulses during RUN are ignored.
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h4A; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("ign.busy c%0d", c), 32'(busy8), 32'd1);
      if (c == 3 || c == 5) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    check("ign.done", 32'(done8), 32'd1);
    check("ign.result", 32'(res8), 32'h7F);
    check("ign.carry", 32'(co8), 32'd0);
    check("ign.ovf", 32'(ov8), 32'd0);

    // Back-to-back start straight from DONE.
    a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b.done_drop", 32'(done8), 32'd0);
    check("b2b.busy_rise", 32'(busy8), 32'd1);
    repeat (7) @(negedge clk);
    check("b2b.busy_last", 32'(busy8), 32'd1);
    @(negedge clk);
    check("b2b.done", 32'(done8), 32'd1);
    check("b2b.result", 32'(res8), 32'h80);
    check("b2b.carry", 32'(co8), 32'd0);
    check("b2b.ovf", 32'(ov8), 32'd1);

    // Reset in the middle of RUN discards the partial result and carry.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("mid.busy c%0d", c), 32'(busy8), 32'd1);
      if (c < 4) @(negedge clk);
    end
    rst_n8 = 1'b0;
    @(negedge clk);
    check("mid.rst_busy", 32'(busy8), 32'd0);
    check("mid.rst_done", 32'(done8), 32'd0);
    check("mid.rst_result", 32'(res8), 32'd0);
    check("mid.rst_carry", 32'(co8), 32'd0);
    check("mid.rst_ovf", 32'(ov8), 32'd0);
    rst_n8 = 1'b1;
    run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      model(8, 32'(ra), 32'(rb), rs, er, eco, eov);
      run8(ra, rb, rs, 8'(er), eco, eov, $sformatf("rand%0d", i));
    end

    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 2; x++)
        for (int y = 0; y < 2; y++)
          run_small(1, x, y, s[0]);

    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 8; y++)
          run_small(3, x, y, s[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
